// File: rtl/mem_port_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Fetch and data requesters share one memory port through this arbiter.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data requests.
// Tracks contested data wins so fetch is never starved past STARVE_LIMIT.
module arb_priority
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic take,
    output logic i_win,
    output logic d_win
);

    localparam int unsigned SW = cnt_width(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          force_i;

    always_comb begin
        force_i = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT));
        d_win   = d_req && !(i_req && force_i);
        i_win   = i_req && !d_win;
    end

    // Only a data win that beat a waiting fetch counts towards starvation.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (take) begin
            if (i_win)
                starve_cnt <= '0;
            else if (d_win && i_req && (STARVE_LIMIT != 0))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data over fetch, one transaction in flight.
// Define MEM_PORT_ARB_STATS_EN to build the grant/conflict statistics counters.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_func3,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_ra,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output logic        mem_wen,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rd,
    output logic        busy,
    output logic [31:0] stat_i_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_conflicts
);

    localparam int unsigned CW = cnt_width(READ_LATENCY);

    arb_state_t    state;
    owner_t        owner;
    logic [CW-1:0] cnt;
    logic          store;
    logic          accept;
    logic          resp;
    logic          take;
    logic          i_win;
    logic          d_win;

    arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk  (clk),
        .reset(reset),
        .i_req(i_req),
        .d_req(d_req),
        .take (accept),
        .i_win(i_win),
        .d_win(d_win)
    );

    always_comb begin
        accept  = !reset && (state == ARB_IDLE || state == ARB_RESP);
        resp    = !reset && (state == ARB_RESP);
        i_gnt   = accept && i_win;
        d_gnt   = accept && d_win;
        take    = i_gnt || d_gnt;
        i_done  = resp && (owner == OWN_I);
        d_done  = resp && (owner == OWN_D);
        i_rdata = i_done ? mem_rd : '0;
        d_rdata = (d_done && !store) ? mem_rd : '0;
        busy    = (state != ARB_IDLE);
    end

    // Write enable lives only in the first ACCESS cycle of a store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_I;
            cnt       <= '0;
            store     <= 1'b0;
            mem_ra    <= '0;
            mem_wa    <= '0;
            mem_wd    <= '0;
            mem_wen   <= 1'b0;
            mem_func3 <= '0;
        end else begin
            mem_wen <= 1'b0;
            if (take) begin
                state     <= ARB_ACCESS;
                cnt       <= CW'(READ_LATENCY);
                owner     <= d_gnt ? OWN_D : OWN_I;
                store     <= d_gnt && d_wen;
                mem_ra    <= d_gnt ? d_addr : i_addr;
                mem_wa    <= d_gnt ? d_addr : i_addr;
                mem_wd    <= d_gnt ? d_wdata : '0;
                mem_wen   <= d_gnt && d_wen;
                mem_func3 <= d_gnt ? d_func3 : FUNC3_WORD;
            end else if (state == ARB_ACCESS) begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1))
                    state <= ARB_RESP;
            end else if (state == ARB_RESP) begin
                state <= ARB_IDLE;
            end
        end
    end

`ifdef MEM_PORT_ARB_STATS_EN
    logic [31:0] n_i;
    logic [31:0] n_d;
    logic [31:0] n_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_i <= '0;
            n_d <= '0;
            n_c <= '0;
        end else begin
            if (i_gnt)
                n_i <= n_i + 32'd1;
            if (d_gnt)
                n_d <= n_d + 32'd1;
            if (accept && i_req && d_req)
                n_c <= n_c + 32'd1;
        end
    end

    assign stat_i_grants  = n_i;
    assign stat_d_grants  = n_d;
    assign stat_conflicts = n_c;
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int RL  = 1;
    localparam int SL  = 4;
    localparam int RL3 = 3;
`ifdef MEM_PORT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0, d_wen = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rd = 0;
    logic [2:0]  d_func3 = 0;
    logic        i_gnt, i_done, d_gnt, d_done, mem_wen, busy;
    logic [31:0] i_rdata, d_rdata, mem_ra, mem_wa, mem_wd;
    logic [2:0]  mem_func3;
    logic [31:0] st_i, st_d, st_c;

    logic        b_i_req = 0, b_d_req = 0, b_d_wen = 0;
    logic [31:0] b_i_addr = 0, b_d_addr = 0, b_d_wdata = 0, b_mem_rd = 0;
    logic [2:0]  b_d_func3 = 3'b010;
    logic        b_i_gnt, b_i_done, b_d_gnt, b_d_done, b_mem_wen, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_ra, b_mem_wa, b_mem_wd;
    logic [2:0]  b_mem_func3;
    logic [31:0] b_st_i, b_st_d, b_st_c;

    mem_port_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_func3(d_func3), .d_gnt(d_gnt),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_wen(mem_wen), .mem_func3(mem_func3), .mem_rd(mem_rd),
        .busy(busy), .stat_i_grants(st_i), .stat_d_grants(st_d),
        .stat_conflicts(st_c)
    );

    mem_port_arbiter #(.READ_LATENCY(RL3), .STARVE_LIMIT(SL)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt),
        .i_done(b_i_done), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_wen(b_d_wen), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_func3(b_d_func3), .d_gnt(b_d_gnt),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_ra(b_mem_ra), .mem_wa(b_mem_wa), .mem_wd(b_mem_wd),
        .mem_wen(b_mem_wen), .mem_func3(b_mem_func3), .mem_rd(b_mem_rd),
        .busy(b_busy), .stat_i_grants(b_st_i), .stat_d_grants(b_st_d),
        .stat_conflicts(b_st_c)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] backing [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] rdb(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rdr(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the memory model writes and reads just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_wen)
            backing[mem_wa] = mem_wd;
        if (b_mem_wen)
            backing[b_mem_wa] = b_mem_wd;
        mem_rd   = rdb(mem_ra);
        b_mem_rd = rdb(b_mem_ra);
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        string       ord;
        bit          ion, don, ew_i, ew_d, acc, p_d, e_wen;
        int          next_ok, last_g, p_cyc, streak;
        int          ig, dg, cf;
        logic [31:0] p_data, e_ra, e_wd;
        logic [2:0]  e_f3;

        backing[32'h1000_0000] = 32'h0000_0013;
        refm[32'h1000_0000]    = 32'h0000_0013;

        // Reset: outputs quiet even with requests pending
        reset = 1;
        tick();
        tick();
        i_req = 1;
        d_req = 1;
        settle();
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_ra", mem_ra, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_i_done", i_done, 0);
        i_req = 0;
        d_req = 0;
        reset = 0;

        // Fetch only
        i_req  = 1;
        i_addr = 32'h1000_0000;
        settle();
        chk("f_i_gnt", i_gnt, 1);
        chk("f_d_gnt", d_gnt, 0);
        tick();
        i_req = 0;
        settle();
        chk("f_mem_ra", mem_ra, 32'h1000_0000);
        chk("f_func3", mem_func3, 3'b010);
        chk("f_busy", busy, 1);
        chk("f_early_done", i_done, 0);
        tick();
        settle();
        chk("f_i_done", i_done, 1);
        chk("f_i_rdata", i_rdata, 32'h0000_0013);
        tick();
        settle();
        chk("f_done_pulse", i_done, 0);
        chk("f_idle", busy, 0);

        // Store then back-to-back load in the store's done cycle
        d_req   = 1;
        d_wen   = 1;
        d_addr  = 32'h2000_0010;
        d_wdata = 32'hDEAD_BEEF;
        d_func3 = 3'b010;
        settle();
        chk("s_d_gnt", d_gnt, 1);
        chk("s_i_gnt", i_gnt, 0);
        tick();
        d_req = 0;
        settle();
        chk("s_wen_c1", mem_wen, 1);
        chk("s_mem_wa", mem_wa, 32'h2000_0010);
        chk("s_mem_wd", mem_wd, 32'hDEAD_BEEF);
        tick();
        settle();
        chk("s_wen_c2", mem_wen, 0);
        chk("s_d_done", d_done, 1);
        chk("s_d_rdata", d_rdata, 0);
        d_req   = 1;
        d_wen   = 0;
        d_wdata = 0;
        settle();
        chk("l_b2b_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        settle();
        chk("l_mem_ra", mem_ra, 32'h2000_0010);
        chk("l_wen", mem_wen, 0);
        tick();
        settle();
        chk("l_d_done", d_done, 1);
        chk("l_d_rdata", d_rdata, 32'hDEAD_BEEF);
        tick();

        // Simultaneous requests from IDLE
        i_req  = 1;
        i_addr = 32'h1000_0000;
        d_req  = 1;
        d_addr = 32'h2000_0010;
        settle();
        chk("c_d_gnt", d_gnt, 1);
        chk("c_i_gnt", i_gnt, 0);
        tick();
        d_req = 0;
        settle();
        chk("c_no_gnt_access", i_gnt, 0);
        tick();
        settle();
        chk("c_d_done", d_done, 1);
        chk("c_i_gnt_b2b", i_gnt, 1);
        tick();
        i_req = 0;
        tick();
        settle();
        chk("c_i_done", i_done, 1);
        chk("c_i_rdata", i_rdata, 32'h0000_0013);
        chk("c_stat_conf", st_c, STATS ? 32'd1 : 32'd0);
        chk("c_stat_i", st_i, STATS ? 32'd2 : 32'd0);
        chk("c_stat_d", st_d, STATS ? 32'd3 : 32'd0);
        tick();

        // Starvation guard with both requests held
        ord   = "DDDDIDDDDI";
        i_req = 1;
        d_req = 1;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("sv_d_gnt%0d", k), d_gnt, ord[k] == "D");
            chk($sformatf("sv_i_gnt%0d", k), i_gnt, ord[k] == "I");
            tick();
            if (k == 9) begin
                i_req = 0;
                d_req = 0;
            end
            tick();
            settle();
            chk($sformatf("sv_d_done%0d", k), d_done, ord[k] == "D");
        end
        tick();

        // Reset during ACCESS of a load discards it
        d_req  = 1;
        d_wen  = 0;
        d_addr = 32'h2000_0010;
        settle();
        chk("r_d_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        reset = 1;
        settle();
        chk("r_done_in_rst", d_done, 0);
        tick();
        reset = 0;
        settle();
        chk("r_busy", busy, 0);
        chk("r_d_done", d_done, 0);
        chk("r_mem_wen", mem_wen, 0);
        chk("r_mem_ra", mem_ra, 0);
        chk("r_stat_i", st_i, 0);
        chk("r_stat_d", st_d, 0);
        chk("r_stat_c", st_c, 0);
        tick();
        settle();
        chk("r_no_late_done", d_done, 0);

        // READ_LATENCY=3 instance
        b_d_req  = 1;
        b_d_addr = 32'h2000_0010;
        settle();
        chk("l3_d_gnt", b_d_gnt, 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            b_d_req  = 0;
            b_i_req  = 1;
            b_i_addr = 32'h1000_0000;
            settle();
            chk($sformatf("l3_busy%0d", c), b_busy, 1);
            chk($sformatf("l3_nodone%0d", c), b_d_done, 0);
            chk($sformatf("l3_no_i_gnt%0d", c), b_i_gnt, 0);
        end
        tick();
        settle();
        chk("l3_d_done", b_d_done, 1);
        chk("l3_d_rdata", b_d_rdata, 32'hDEAD_BEEF);
        chk("l3_i_gnt", b_i_gnt, 1);
        tick();
        b_i_req = 0;
        tick();
        tick();
        settle();
        chk("l3_i_early", b_i_done, 0);
        tick();
        settle();
        chk("l3_i_done", b_i_done, 1);
        chk("l3_i_rdata", b_i_rdata, 32'h0000_0013);
        tick();

        // Randomized traffic against a transaction-level model
        ion = 0; don = 0;
        next_ok = cyc; last_g = -100; p_cyc = -1; streak = 0;
        ig = 0; dg = 0; cf = 0;
        p_d = 0; p_data = 0; e_ra = 0; e_wd = 0; e_f3 = 0; e_wen = 0;
        for (int n = 0; n < 400; n++) begin
            i_req = ion;
            d_req = don;
            settle();
            acc  = (cyc >= next_ok);
            ew_i = 0;
            ew_d = 0;
            if (acc) begin
                if (ion && don) begin
                    if (SL > 0 && streak == SL) ew_i = 1;
                    else ew_d = 1;
                end else if (don) begin
                    ew_d = 1;
                end else if (ion) begin
                    ew_i = 1;
                end
            end
            chk("rnd_i_gnt", i_gnt, ew_i);
            chk("rnd_d_gnt", d_gnt, ew_d);
            chk("rnd_busy", busy, (cyc > last_g && cyc <= last_g + RL + 1));
            chk("rnd_i_done", i_done, (p_cyc == cyc && !p_d));
            chk("rnd_d_done", d_done, (p_cyc == cyc && p_d));
            if (p_cyc == cyc && !p_d) chk("rnd_i_rdata", i_rdata, p_data);
            if (p_cyc == cyc && p_d) chk("rnd_d_rdata", d_rdata, p_data);
            if (cyc == last_g + 1) begin
                chk("rnd_mem_ra", mem_ra, e_ra);
                chk("rnd_func3", mem_func3, e_f3);
                chk("rnd_mem_wen", mem_wen, e_wen);
                if (e_wen) chk("rnd_mem_wd", mem_wd, e_wd);
            end
            if (ew_i || ew_d) begin
                if (ion && don) cf++;
                if (ew_i) streak = 0;
                else if (ion) streak++;
                last_g  = cyc;
                next_ok = cyc + RL + 1;
                p_cyc   = cyc + RL + 1;
                p_d     = ew_d;
                e_ra    = ew_d ? d_addr : i_addr;
                e_f3    = ew_d ? d_func3 : 3'b010;
                e_wen   = ew_d && d_wen;
                e_wd    = d_wdata;
                if (ew_d) begin
                    dg++;
                    p_data = d_wen ? 32'd0 : rdr(d_addr);
                    if (d_wen) refm[d_addr] = d_wdata;
                    don = 0;
                end else begin
                    ig++;
                    p_data = rdr(i_addr);
                    ion = 0;
                end
            end
            tick();
            if (n < 392) begin
                if (!ion && $urandom_range(0, 99) < 70) begin
                    ion    = 1;
                    i_addr = 32'h3000_0000 | ($urandom_range(0, 15) << 2);
                end
                if (!don && $urandom_range(0, 99) < 70) begin
                    don     = 1;
                    d_wen   = 1'($urandom_range(0, 1));
                    d_addr  = 32'h3000_0000 | ($urandom_range(0, 15) << 2);
                    d_wdata = $urandom;
                    d_func3 = 3'($urandom_range(0, 7));
                end
            end
        end
        settle();
        chk("rnd_stat_i", st_i, STATS ? 32'(ig) : 32'd0);
        chk("rnd_stat_d", st_d, STATS ? 32'(dg) : 32'd0);
        chk("rnd_stat_c", st_c, STATS ? 32'(cf) : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch path and the load/store path of the multicycle core. Each requester uses a valid/grant request handshake and receives a done pulse with read data. One transaction is in flight at a time. Data side has priority, and a starvation guard bounds fetch stalls. Sits between the core control FSM/datapath and the memory model.

Parameters:
READ_LATENCY, 1, memory read latency in cycles (>=1); number of ACCESS cycles per transaction
STARVE_LIMIT, 4, consecutive contested data wins before fetch is forced to win; 0 = pure data priority

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
i_req  input  1  fetch request valid; held with i_addr until i_gnt seen
i_addr  input  32  fetch address
i_gnt  output  1  combinational accept of fetch request this cycle
i_done  output  1  one-cycle pulse, fetch complete
i_rdata  output  32  instruction word, valid when i_done
d_req  input  1  data request valid; payload held until d_gnt
d_wen  input  1  1 = store, 0 = load
d_addr  input  32  data address
d_wdata  input  32  store data
d_func3  input  3  access width/sign, passed to memory
d_gnt  output  1  combinational accept of data request
d_done  output  1  one-cycle pulse, data access complete
d_rdata  output  32  load data when d_done (0 for stores)
mem_ra  output  32  memory read address (registered)
mem_wa  output  32  memory write address (registered)
mem_wd  output  32  memory write data (registered)
mem_wen  output  1  memory write enable
mem_func3  output  3  memory access func3 (fetch always 3'b010)
mem_rd  input  32  memory read data
busy  output  1  high in ACCESS and RESP
stat_i_grants, stat_d_grants, stat_conflicts  output  32 each  statistics (see Optional Feature)

Behaviour:
- States ARB_IDLE, ARB_ACCESS, ARB_RESP. Reset: ARB_IDLE; all registered outputs 0; gnt/done/rdata 0 while reset high; in-flight transaction discarded, no done pulse; starve counter 0.
- Accept point: ARB_IDLE or ARB_RESP. At most one gnt per cycle, and only in those states. Request is taken on the edge ending the gnt cycle. mem_ra/mem_wa/mem_wd/mem_func3/owner latch on that edge; go to ARB_ACCESS with cnt=READ_LATENCY.
- Priority: d over i. Contested = both reqs high at an accept point. Contested data win increments starve_cnt. Fetch grant clears it. starve_cnt==STARVE_LIMIT (limit>0) → fetch wins.
- ARB_ACCESS: cnt decrements each edge; at cnt==1 → ARB_RESP. mem_wen=1 only in first ACCESS cycle of a store, otherwise 0.
- ARB_RESP: owner's done=1. For loads/fetch, rdata = mem_rd (address still held); store d_rdata=0. Next edge → ARB_ACCESS if a req is granted this cycle (back-to-back), else ARB_IDLE.
- Latency: done in cycle gnt+READ_LATENCY+1. Back-to-back throughput: one per READ_LATENCY+1 cycles.
- No gnt in ARB_ACCESS regardless of req. Requesters must keep req and payload stable until gnt.
- A requester may re-assert req in its own done cycle; it is arbitrated normally.

Optional Feature:
MEM_PORT_ARB_STATS_EN.
- Defined: stat_i_grants/stat_d_grants increment per accepted request, and stat_conflicts per contested accept point. Counters wrap at 2^32 and clear on reset.
- Undefined: counters not built; stat_* tied to 0.

Decomposition:
- Package mem_port_arb_pkg: arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RESP}, owner_t {OWN_I, OWN_D}, FUNC3_WORD=3'b010.
- Sub-module arb_priority: combinational winner select plus starve_cnt register, parameterised by STARVE_LIMIT.

Test Plan:
- Fetch only, READ_LATENCY=1: i_req addr 0x1000_0000 in IDLE at cycle 0 → i_gnt cycle 0; mem_ra=0x1000_0000 from cycle 1; i_done cycle 2 with i_rdata=0x0000_0013 (model contents).
- Store then load: d_req wen=1, addr 0x2000_0010, wdata 0xDEAD_BEEF, func3 010 → mem_wen high exactly cycle 1; d_done cycle 2. Following load of 0x2000_0010 → d_rdata=0xDEAD_BEEF.
- Simultaneous i_req/d_req in IDLE → d_gnt only. i_gnt in d_done cycle (back-to-back); i_done 2 cycles after d_done; stat_conflicts=1 with macro.
- Both reqs held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Reset asserted in ACCESS of a load → next cycle IDLE, busy=0, no done pulse, mem_wen=0, stats 0.
- READ_LATENCY=3 load gnt at cycle 0 → ACCESS cycles 1-3, d_done cycle 4; i_req during ACCESS not granted until cycle 4.
